// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the cache fill arbiter
// Purpose: arbiter FSM state enum, cache line geometry and line address helpers.
// Ports: none (package).

package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int          LINE_WORDS = 8;
   localparam int          WORD_BYTES = 2;
   localparam logic [15:0] LINE_MASK  = 16'hFFF0;

   // First byte address of the line holding byte address a.
   function automatic logic [15:0] line_base(input logic [15:0] a);
      return a & LINE_MASK;
   endfunction

   // Byte address of word idx within the line starting at base.
   function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] idx);
      return base + (16'(idx) * 16'(WORD_BYTES));
   endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - 3-bit word counter for line fills
// Purpose: counts words of a line transfer; last flags the final word index.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         synchronous clear to zero (dominates en)
//   en          increment by one
//   count[2:0]  current word index
//   last        count equals LAST

module fill_counter #(
   parameter int LAST = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [2:0] count,
   output logic       last
);

   localparam logic [2:0] LAST_CNT = 3'(LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= 3'd0;
      end else if (en) begin
         count <= count + 3'd1;
      end
   end

   assign last = (count == LAST_CNT);

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - I/D cache line fill and write-through store arbiter
// Purpose: shares one single-port memory between I-cache fills, D-cache fills and
//   D-cache write-through stores. Priority d_wr > d_miss > i_miss; with the
//   ARB_RR_EN macro defined, d_miss/i_miss ties alternate.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_miss, i_miss_addr          I-cache miss request (level) and byte address
//   d_miss, d_miss_addr          D-cache miss request (level) and byte address
//   d_wr, d_wr_addr, d_wr_data   store request, held until d_wr_ack
//   d_wr_ack                     one-cycle store-issued pulse
//   mem_en/mem_wr/mem_addr/mem_wdata  memory command
//   mem_rdata, mem_rvalid        pipelined read return
//   fill_data, fill_word         per-word cache data write
//   fill_we_i/d, fill_tag_we_i/d data and tag write enables per cache
//   i_fill_done, d_fill_done     one-cycle fill complete pulses
//   busy                         arbiter not idle

module cache_fill_arbiter #(
   parameter int MEM_LAT    = 4,
   parameter int LINE_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_miss,
   input  logic        d_miss,
   input  logic [15:0] i_miss_addr,
   input  logic [15:0] d_miss_addr,
   input  logic        d_wr,
   input  logic [15:0] d_wr_addr,
   input  logic [15:0] d_wr_data,
   output logic        d_wr_ack,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [15:0] fill_data,
   output logic [2:0]  fill_word,
   output logic        fill_we_i,
   output logic        fill_we_d,
   output logic        fill_tag_we_i,
   output logic        fill_tag_we_d,
   output logic        i_fill_done,
   output logic        d_fill_done,
   output logic        busy
);

   import cpu_pkg::*;

   localparam int               LAT_W   = (MEM_LAT >= 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(MEM_LAT);

   arb_state_t       state;
   logic             side_d;     // 1: current fill belongs to the D-cache
   logic [15:0]      base_q;
   logic [LAT_W-1:0] wait_cnt;
   logic [2:0]       iss_cnt;
   logic [2:0]       rx_cnt;
   logic             iss_last;
   logic             rx_last;
   logic             in_idle;
   logic             in_fill;
   logic             lat_ok;
   logic             rx_take;
   logic             iss_en;
   logic             grant_store;
   logic             grant_fill;
   logic             grant_d;
`ifdef ARB_RR_EN
   logic             rr_last_d;  // winner of the most recent d_miss/i_miss tie
`endif

   assign in_idle = (state == IDLE);
   assign in_fill = (state == FILL);

   // No read can return before MEM_LAT cycles after the first issue, so the
   // receive window opens only then; stray mem_rvalid earlier is dropped.
   assign lat_ok  = (wait_cnt == LAT_CNT);
   assign rx_take = in_fill && lat_ok && mem_rvalid;
   assign iss_en  = in_fill && mem_en && !iss_last;

   fill_counter #(.LAST(LINE_WORDS - 1)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (in_idle),
      .en    (iss_en),
      .count (iss_cnt),
      .last  (iss_last)
   );

   fill_counter #(.LAST(LINE_WORDS - 1)) u_rx_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (in_idle),
      .en    (rx_take),
      .count (rx_cnt),
      .last  (rx_last)
   );

   always_comb begin
      grant_store = 1'b0;
      grant_fill  = 1'b0;
      grant_d     = 1'b0;
      if (d_wr) begin
         grant_store = 1'b1;
      end else if (d_miss && i_miss) begin
         grant_fill = 1'b1;
`ifdef ARB_RR_EN
         grant_d    = !rr_last_d;
`else
         grant_d    = 1'b1;
`endif
      end else if (d_miss) begin
         grant_fill = 1'b1;
         grant_d    = 1'b1;
      end else if (i_miss) begin
         grant_fill = 1'b1;
      end
   end

   // Read returns are written straight through to the cache in the same cycle.
   assign fill_data     = rx_take ? mem_rdata : 16'd0;
   assign fill_word     = rx_take ? rx_cnt : 3'd0;
   assign fill_we_i     = rx_take && !side_d;
   assign fill_we_d     = rx_take && side_d;
   assign fill_tag_we_i = fill_we_i && rx_last;
   assign fill_tag_we_d = fill_we_d && rx_last;
   assign busy          = !in_idle;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         side_d      <= 1'b0;
         base_q      <= 16'd0;
         wait_cnt    <= '0;
         mem_en      <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= 16'd0;
         mem_wdata   <= 16'd0;
         d_wr_ack    <= 1'b0;
         i_fill_done <= 1'b0;
         d_fill_done <= 1'b0;
`ifdef ARB_RR_EN
         rr_last_d   <= 1'b0;
`endif
      end else begin
         if (!in_fill) begin
            wait_cnt <= '0;
         end else if (!lat_ok) begin
            wait_cnt <= wait_cnt + LAT_W'(1);
         end

         case (state)
            IDLE: begin
               if (grant_store) begin
                  state     <= STORE;
                  mem_en    <= 1'b1;
                  mem_wr    <= 1'b1;
                  mem_addr  <= d_wr_addr;
                  mem_wdata <= d_wr_data;
                  d_wr_ack  <= 1'b1;
               end else if (grant_fill) begin
                  state    <= FILL;
                  side_d   <= grant_d;
                  base_q   <= line_base(grant_d ? d_miss_addr : i_miss_addr);
                  mem_en   <= 1'b1;
                  mem_addr <= line_base(grant_d ? d_miss_addr : i_miss_addr);
`ifdef ARB_RR_EN
                  if (d_miss && i_miss) begin
                     rr_last_d <= grant_d;
                  end
`endif
               end
            end
            STORE: begin
               state     <= IDLE;
               mem_en    <= 1'b0;
               mem_wr    <= 1'b0;
               mem_addr  <= 16'd0;
               mem_wdata <= 16'd0;
               d_wr_ack  <= 1'b0;
            end
            FILL: begin
               // mem_addr always holds the word the issue counter points at.
               if (mem_en) begin
                  if (iss_last) begin
                     mem_en   <= 1'b0;
                     mem_addr <= 16'd0;
                  end else begin
                     mem_addr <= word_addr(base_q, iss_cnt + 3'd1);
                  end
               end
               if (rx_take && rx_last) begin
                  state       <= DONE;
                  i_fill_done <= !side_d;
                  d_fill_done <= side_d;
               end
            end
            DONE: begin
               state       <= IDLE;
               i_fill_done <= 1'b0;
               d_fill_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter

module tb_cache_fill_arbiter;

   localparam int MEM_LAT    = 4;
   localparam int LINE_WORDS = 8;
   localparam int FILL_LEN   = LINE_WORDS + MEM_LAT + 1;
`ifdef ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_miss = 1'b0;
   logic        d_miss = 1'b0;
   logic [15:0] i_miss_addr = 16'd0;
   logic [15:0] d_miss_addr = 16'd0;
   logic        d_wr = 1'b0;
   logic [15:0] d_wr_addr = 16'd0;
   logic [15:0] d_wr_data = 16'd0;
   logic        d_wr_ack;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'd0;
   logic        mem_rvalid = 1'b0;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        fill_we_i;
   logic        fill_we_d;
   logic        fill_tag_we_i;
   logic        fill_tag_we_d;
   logic        i_fill_done;
   logic        d_fill_done;
   logic        busy;

   always #5 clk = ~clk;

   cache_fill_arbiter #(.MEM_LAT(MEM_LAT), .LINE_WORDS(LINE_WORDS)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_miss        (i_miss),
      .d_miss        (d_miss),
      .i_miss_addr   (i_miss_addr),
      .d_miss_addr   (d_miss_addr),
      .d_wr          (d_wr),
      .d_wr_addr     (d_wr_addr),
      .d_wr_data     (d_wr_data),
      .d_wr_ack      (d_wr_ack),
      .mem_en        (mem_en),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .fill_data     (fill_data),
      .fill_word     (fill_word),
      .fill_we_i     (fill_we_i),
      .fill_we_d     (fill_we_d),
      .fill_tag_we_i (fill_tag_we_i),
      .fill_tag_we_d (fill_tag_we_d),
      .i_fill_done   (i_fill_done),
      .d_fill_done   (d_fill_done),
      .busy          (busy)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: the transaction currently owning the memory port.
   int          t_kind = 0;      // 0 none, 1 store, 2 fill
   int          t_g = 0;         // grant cycle
   int          t_end = 0;       // last busy cycle
   logic [15:0] t_addr = 16'd0;  // store address or line base
   logic [15:0] t_data = 16'd0;
   bit          t_side_d = 1'b0;
   bit          last_d = 1'b0;   // winner of the last tie
   bit          spur_en = 1'b0;

   typedef struct {
      int          due;
      logic [15:0] data;
   } ret_t;
   ret_t mq[$];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'h0101) ^ 16'hC35A;
   endfunction

   function automatic bit model_idle();
      return (t_kind == 0) || (cyc > t_end);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Arbitration decision for the current cycle, from the requests as driven.
   task automatic decide();
      if (rst) begin
         t_kind = 0;
         last_d = 1'b0;
      end else if (model_idle()) begin
         if (d_wr) begin
            t_kind = 1; t_g = cyc; t_end = cyc + 1;
            t_addr = d_wr_addr; t_data = d_wr_data;
         end else if (d_miss || i_miss) begin
            if (d_miss && i_miss) begin
               t_side_d = RR_EN ? !last_d : 1'b1;
               last_d   = t_side_d;
            end else begin
               t_side_d = d_miss;
            end
            t_kind = 2; t_g = cyc; t_end = cyc + FILL_LEN;
            t_addr = (t_side_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
         end else begin
            t_kind = 0;
         end
      end
   endtask

   task automatic step();
      logic        een, ewr, ewe_i, ewe_d, etag_i, etag_d, eack, edone_i, edone_d, ebusy;
      logic [15:0] ea, ewd, efd;
      logic [2:0]  ewrd;
      int          off;
      decide();
      @(posedge clk);
      #1;
      cyc++;
      if (mem_en && !mem_wr) mq.push_back('{due: cyc + MEM_LAT, data: mem_word(mem_addr)});
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
      if (mq.size() > 0 && mq[0].due == cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mq[0].data;
         void'(mq.pop_front());
      end else if (spur_en && model_idle() && $urandom_range(0, 1) == 1) begin
         mem_rvalid = 1'b1;
      end
      #1;
      {een, ewr, ewe_i, ewe_d, etag_i, etag_d, eack, edone_i, edone_d} = '0;
      ea = 16'd0; ewd = 16'd0; efd = 16'd0; ewrd = 3'd0;
      off   = cyc - t_g;
      ebusy = !model_idle();
      if (t_kind == 1 && off == 1) begin
         een = 1'b1; ewr = 1'b1; ea = t_addr; ewd = t_data; eack = 1'b1;
      end
      if (t_kind == 2 && ebusy) begin
         if (off >= 1 && off <= LINE_WORDS) begin
            een = 1'b1;
            ea  = t_addr + 16'(2 * (off - 1));
         end
         if (off >= MEM_LAT + 1 && off <= MEM_LAT + LINE_WORDS) begin
            ewrd   = 3'(off - MEM_LAT - 1);
            efd    = mem_word(t_addr + 16'(2 * (off - MEM_LAT - 1)));
            ewe_i  = !t_side_d;
            ewe_d  = t_side_d;
            etag_i = !t_side_d && (off == MEM_LAT + LINE_WORDS);
            etag_d = t_side_d && (off == MEM_LAT + LINE_WORDS);
         end
         if (off == FILL_LEN) begin
            edone_i = !t_side_d;
            edone_d = t_side_d;
         end
      end
      chk("mem_cmd", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({een, ewr, ea, ewd}));
      chk("fill_wr", 64'({fill_we_i, fill_we_d, fill_tag_we_i, fill_tag_we_d, fill_word, fill_data}),
          64'({ewe_i, ewe_d, etag_i, etag_d, ewrd, efd}));
      chk("ctl", 64'({d_wr_ack, i_fill_done, d_fill_done, busy}), 64'({eack, edone_i, edone_d, ebusy}));
      if (eack) d_wr = 1'b0;
      if (edone_i) i_miss = 1'b0;
      if (edone_d) d_miss = 1'b0;
   endtask

   task automatic settle(input int max);
      int n;
      n = 0;
      while ((i_miss || d_miss || d_wr || !model_idle()) && n < max) begin
         step();
         n++;
      end
      vectors++;
      assert (n < max) else begin
         miscompares++;
         $error("FAIL settle_timeout observed=%0d expected_below=%0d", n, max);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      // I miss at 0x1236: full line 0x1230..0x123E, done 13 cycles after grant
      i_miss = 1'b1; i_miss_addr = 16'h1236;
      step();
      n = 0;
      while (!i_fill_done && n < 40) begin step(); n++; end
      chk("miss_latency", 64'(cyc - t_g), 64'(FILL_LEN));
      settle(40);

      // Simultaneous D and I misses, twice back to back
      for (int k = 0; k < 2; k++) begin
         d_miss = 1'b1; d_miss_addr = 16'h8A5C;
         i_miss = 1'b1; i_miss_addr = 16'h0104;
         settle(80);
      end

      // Store arriving during an I fill waits for DONE
      i_miss = 1'b1; i_miss_addr = 16'h2468;
      repeat (3) step();
      d_wr = 1'b1; d_wr_addr = 16'h4000; d_wr_data = 16'hBEEF;
      settle(60);

      // Reset after the third return, late returns and stray rvalid ignored
      i_miss = 1'b1; i_miss_addr = 16'h3332;
      step();
      n = 0;
      while (!(t_kind == 2 && cyc - t_g == MEM_LAT + 3) && n < 30) begin step(); n++; end
      rst = 1'b1; i_miss = 1'b0;
      step();
      rst = 1'b0;
      spur_en = 1'b1;
      repeat (14) step();

      // Randomized mix of requests, drops and resets
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 3)) step();
         if ($urandom_range(0, 1) == 1) begin i_miss = 1'b1; i_miss_addr = 16'($urandom); end
         if ($urandom_range(0, 1) == 1) begin d_miss = 1'b1; d_miss_addr = 16'($urandom); end
         if ($urandom_range(0, 2) == 0) begin
            d_wr = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
         end
         repeat ($urandom_range(1, 8)) step();
         case ($urandom_range(0, 4))
            0: if (t_kind == 2 && !model_idle()) begin
                  if (t_side_d) d_miss = 1'b0;
                  else          i_miss = 1'b0;
               end
            1: if (!d_wr) begin
                  d_wr = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
               end
            2: begin
                  rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
                  step();
                  rst = 1'b0;
                  for (int k = 0; k < 20 && mq.size() > 0; k++) step();
               end
            default: ;
         endcase
         settle(200);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
